muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (MUL..REMU) at width XLEN.
// A single shared shift/add datapath performs radix-2 multiply and restoring divide.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   i_start        request strobe, sampled only while idle
//   i_op           funct3 operation select
//   i_src_a        multiplicand / dividend
//   i_src_b        multiplier / divisor
//   o_busy         high from the cycle after accept through the done cycle
//   o_done         one-cycle completion pulse
//   o_result       last completed result, held until the next completion
//   o_zero         o_result == 0, registered with o_result
//   o_div_by_zero  last completed op was a divide/remainder by zero
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [2:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_dbz;

    // Operand conditioning at accept time
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_is_div;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_a_signed = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                        (i_op == OP_MULHSU) || (i_op == OP_DIV) ||
                        (i_op == OP_REM);
    assign w_b_signed = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                        (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_a_neg  = w_a_signed & i_src_a[XLEN-1];
    assign w_b_neg  = w_b_signed & i_src_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~i_src_a + 1'b1) : i_src_a;
    assign w_b_mag  = w_b_neg ? (~i_src_b + 1'b1) : i_src_b;
    assign w_is_div = i_op[2];
    assign w_b_zero = (i_src_b == '0);
    // Signed overflow only exists for DIV/REM: op[2]=1, op[0]=0
    assign w_ovf    = i_op[2] & ~i_op[0] &
                      (i_src_a == MIN_NEG) & (&i_src_b);
    assign w_special = w_is_div & (w_b_zero | w_ovf);

    // op[1] distinguishes remainder from quotient within the divide group
    always_comb begin
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = i_op[1] ? i_src_a : '1;
        end else begin
            w_special_res = i_op[1] ? '0 : i_src_a;
        end
    end

    // Multiply step: {hi,lo} holds partial product over multiplier bits;
    // r_b is the multiplicand magnitude.
    logic [XLEN:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};

    // Restoring divide step: {hi,lo} = {remainder, dividend/quotient};
    // r_b is the divisor magnitude.
    logic [XLEN:0]   w_div_shl;
    logic            w_div_ok;
    logic [XLEN-1:0] w_div_sub;
    assign w_div_shl = {r_hi, r_lo[XLEN-1]};
    assign w_div_ok  = (w_div_shl >= {1'b0, r_b});
    // True difference is below 2^XLEN whenever it is kept
    assign w_div_sub = w_div_shl[XLEN-1:0] - r_b;

    // Sign correction and result selection
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quot     = r_neg_res ? (~r_lo + 1'b1) : r_lo;
    assign w_rem      = r_neg_rem ? (~r_hi + 1'b1) : r_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            OP_MUL:    w_fix_res = w_prod_fix[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   w_fix_res = w_quot;
            OP_REM,
            OP_REMU:   w_fix_res = w_rem;
            default:   w_fix_res = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'b000;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op      <= i_op;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_busy    <= 1'b1;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_zero   <= (w_special_res == '0);
                            r_dbz    <= w_b_zero;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                            r_b     <= w_is_div ? w_b_mag : w_a_mag;
                            r_cnt   <= CNT_INIT;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_op[2]) begin
                        if (w_div_ok) begin
                            r_hi <= w_div_sub;
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_div_shl[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_zero   <= (w_fix_res == '0);
                    r_dbz    <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_zero        = r_zero;
    assign o_div_by_zero = r_dbz;

endmodule
